// File: rtl/cmpf_pipelined.sv
// rtl/cmpf_pipelined.sv - elastic IEEE-754 fcmp comparator with a stallable LATENCY-deep result pipeline
// Optional macro CMPF_PIPELINED_DAZ_EN flushes subnormal operands to zero before comparison.
module cmpf_pipelined #(
  parameter int EXP_WIDTH = 8,
  parameter int MAN_WIDTH = 23,
  parameter int PREDICATE = 0,
  parameter int LATENCY   = 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   lhs,
  input  logic                           lhs_valid,
  output logic                           lhs_ready,
  input  logic [EXP_WIDTH+MAN_WIDTH:0]   rhs,
  input  logic                           rhs_valid,
  output logic                           rhs_ready,
  output logic                           result,
  output logic                           result_valid,
  input  logic                           result_ready
);

  localparam int W = 1 + EXP_WIDTH + MAN_WIDTH;

  generate
    if (PREDICATE < 0 || PREDICATE > 13) begin : g_bad_predicate
      $error("cmpf_pipelined: PREDICATE must be 0..13");
    end
    if (LATENCY < 1 || LATENCY > 4) begin : g_bad_latency
      $error("cmpf_pipelined: LATENCY must be 1..4");
    end
    if (EXP_WIDTH < 2 || EXP_WIDTH > 11 || MAN_WIDTH < 2 || MAN_WIDTH > 52) begin : g_bad_width
      $error("cmpf_pipelined: EXP_WIDTH/MAN_WIDTH out of range");
    end
  endgenerate

  logic                 lhs_sign, rhs_sign;
  logic [EXP_WIDTH-1:0] lhs_exp, rhs_exp;
  logic [MAN_WIDTH-1:0] lhs_man, rhs_man;
  logic                 lhs_nan, rhs_nan;
  logic                 lhs_zero, rhs_zero;
  logic                 unordered, both_zero;
  logic                 mag_eq, mag_lt, mag_gt;
  logic                 cmp_eq, cmp_lt, cmp_gt;
  logic                 cmp_bit;

  assign lhs_sign = lhs[W-1];
  assign rhs_sign = rhs[W-1];
  assign lhs_exp  = lhs[W-2:MAN_WIDTH];
  assign rhs_exp  = rhs[W-2:MAN_WIDTH];

  // Mantissas seen by the ordering logic; DAZ builds flush subnormals to a signed zero here.
  always_comb begin
    lhs_man = lhs[MAN_WIDTH-1:0];
    rhs_man = rhs[MAN_WIDTH-1:0];
`ifdef CMPF_PIPELINED_DAZ_EN
    if (lhs_exp == '0) lhs_man = '0;
    if (rhs_exp == '0) rhs_man = '0;
`endif
  end

  assign lhs_nan   = (&lhs_exp) && (|lhs[MAN_WIDTH-1:0]);
  assign rhs_nan   = (&rhs_exp) && (|rhs[MAN_WIDTH-1:0]);
  assign lhs_zero  = (lhs_exp == '0) && (lhs_man == '0);
  assign rhs_zero  = (rhs_exp == '0) && (rhs_man == '0);
  assign unordered = lhs_nan | rhs_nan;
  assign both_zero = lhs_zero & rhs_zero;

  assign mag_eq = {lhs_exp, lhs_man} == {rhs_exp, rhs_man};
  assign mag_lt = {lhs_exp, lhs_man} <  {rhs_exp, rhs_man};
  assign mag_gt = {lhs_exp, lhs_man} >  {rhs_exp, rhs_man};

  // Sign-magnitude ordering: negatives reverse the magnitude compare, +0 and -0 tie.
  always_comb begin
    cmp_eq = both_zero | ((lhs_sign == rhs_sign) & mag_eq);
    cmp_lt = 1'b0;
    cmp_gt = 1'b0;
    if (!both_zero) begin
      if (lhs_sign != rhs_sign) begin
        cmp_lt = lhs_sign;
        cmp_gt = rhs_sign;
      end else if (lhs_sign) begin
        cmp_lt = mag_gt;
        cmp_gt = mag_lt;
      end else begin
        cmp_lt = mag_lt;
        cmp_gt = mag_gt;
      end
    end
  end

  always_comb begin
    cmp_bit = 1'b0;
    case (PREDICATE)
      0:  cmp_bit = !unordered & cmp_eq;
      1:  cmp_bit = !unordered & cmp_gt;
      2:  cmp_bit = !unordered & (cmp_gt | cmp_eq);
      3:  cmp_bit = !unordered & cmp_lt;
      4:  cmp_bit = !unordered & (cmp_lt | cmp_eq);
      5:  cmp_bit = !unordered & !cmp_eq;
      6:  cmp_bit = !unordered;
      7:  cmp_bit = unordered | cmp_eq;
      8:  cmp_bit = unordered | cmp_gt;
      9:  cmp_bit = unordered | cmp_gt | cmp_eq;
      10: cmp_bit = unordered | cmp_lt;
      11: cmp_bit = unordered | cmp_lt | cmp_eq;
      12: cmp_bit = unordered | !cmp_eq;
      13: cmp_bit = unordered;
      default: cmp_bit = 1'b0;
    endcase
  end

  logic [LATENCY-1:0] stage_valid;
  logic [LATENCY-1:0] stage_bit;
  logic               en;
  logic               fire;

  assign en        = !stage_valid[LATENCY-1] | result_ready;
  assign fire      = lhs_valid & rhs_valid & en;
  assign lhs_ready = en & rhs_valid;
  assign rhs_ready = en & lhs_valid;

  // Whole pipe moves in lockstep, so a stall holds bubbles in place rather than squeezing them.
  always_ff @(posedge clk) begin
    if (rst) begin
      stage_valid <= '0;
      stage_bit   <= '0;
    end else if (en) begin
      stage_valid[0] <= fire;
      stage_bit[0]   <= cmp_bit;
      for (int i = 1; i < LATENCY; i++) begin
        stage_valid[i] <= stage_valid[i-1];
        stage_bit[i]   <= stage_bit[i-1];
      end
    end
  end

  assign result       = stage_bit[LATENCY-1];
  assign result_valid = stage_valid[LATENCY-1];

endmodule

// File: tb/tb_cmpf_pipelined.sv
// tb/tb_cmpf_pipelined.sv - randomized self-checking bench for cmpf_pipelined, all 14 predicates
// Bank A: binary32, LATENCY=3. Bank B: binary16, LATENCY=1. Honors CMPF_PIPELINED_DAZ_EN.
module tb_cmpf_pipelined;

  localparam int LA = 3;
  localparam int LB = 1;

  logic        clk = 1'b0;
  logic        rst, lv, rv, rr;
  logic [31:0] la, ra;
  logic [15:0] lb, rb;
  logic [13:0] res_a, vld_a, lrdy_a, rrdy_a;
  logic [13:0] res_b, vld_b, lrdy_b, rrdy_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 14; g++) begin : g_bank
    cmpf_pipelined #(.EXP_WIDTH(8), .MAN_WIDTH(23), .PREDICATE(g), .LATENCY(LA)) u_a (
      .clk(clk), .rst(rst),
      .lhs(la), .lhs_valid(lv), .lhs_ready(lrdy_a[g]),
      .rhs(ra), .rhs_valid(rv), .rhs_ready(rrdy_a[g]),
      .result(res_a[g]), .result_valid(vld_a[g]), .result_ready(rr)
    );
    cmpf_pipelined #(.EXP_WIDTH(5), .MAN_WIDTH(10), .PREDICATE(g), .LATENCY(LB)) u_b (
      .clk(clk), .rst(rst),
      .lhs(lb), .lhs_valid(lv), .lhs_ready(lrdy_b[g]),
      .rhs(rb), .rhs_valid(rv), .rhs_ready(rrdy_b[g]),
      .result(res_b[g]), .result_valid(vld_b[g]), .result_ready(rr)
    );
  end

  // Reference pipeline: one valid flag and 14 predicate bits per slot.
  bit        mv_a [4];
  bit [13:0] mb_a [4];
  bit        mv_b [4];
  bit [13:0] mb_b [4];
  bit        fire_a;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Operand value as a real; infinities become a huge finite magnitude.
  function automatic real fp_value(input logic [31:0] x, input int ew, input int mw, output bit is_nan);
    int unsigned emax, e, m, s;
    int bias;
    real v;
    emax = (32'd1 << ew) - 1;
    e    = (x >> mw) & emax;
    m    = x & ((32'd1 << mw) - 1);
    s    = (x >> (ew + mw)) & 1;
    bias = (1 << (ew - 1)) - 1;
    is_nan = (e == emax) && (m != 0);
    if (e == emax) v = 1.0e300;
    else if (e == 0) begin
`ifdef CMPF_PIPELINED_DAZ_EN
      v = 0.0;
`else
      v = real'(m) * (2.0 ** real'(1 - bias - mw));
`endif
    end else v = (1.0 + real'(m) / (2.0 ** mw)) * (2.0 ** real'(int'(e) - bias));
    return s ? -v : v;
  endfunction

  function automatic logic [13:0] pred_vec(input logic [31:0] a, input logic [31:0] b, input int ew, input int mw);
    bit na, nb, u, eq, lt, gt;
    real va, vb;
    logic [13:0] r;
    va = fp_value(a, ew, mw, na);
    vb = fp_value(b, ew, mw, nb);
    u  = na | nb;
    eq = (va == vb);
    lt = (va < vb);
    gt = (va > vb);
    r[0]  = !u && eq;          r[1]  = !u && gt;
    r[2]  = !u && (gt || eq);  r[3]  = !u && lt;
    r[4]  = !u && (lt || eq);  r[5]  = !u && !eq;
    r[6]  = !u;                r[7]  = u || eq;
    r[8]  = u || gt;           r[9]  = u || gt || eq;
    r[10] = u || lt;           r[11] = u || lt || eq;
    r[12] = u || !eq;          r[13] = u;
    return r;
  endfunction

  function automatic logic [31:0] rnd_fp(input int ew, input int mw, input logic [31:0] other);
    int unsigned emax, s, e, m;
    emax = (32'd1 << ew) - 1;
    s = $urandom % 2;
    e = $urandom % (emax + 1);
    m = $urandom & ((32'd1 << mw) - 1);
    case ($urandom % 8)
      0: begin e = 0; m = 0; end
      1: begin e = emax; m = 0; end
      2: begin e = emax; m = m | 1; end
      3: begin e = 0; m = ($urandom % 4) + 1; end
      4: return other;
      5: return other ^ (32'd1 << (ew + mw));
      default: ;
    endcase
    return (s << (ew + mw)) | (e << mw) | m;
  endfunction

  // One clock: check outputs at negedge against the model, then advance the model across posedge.
  task automatic step(input bit r_, input bit lv_, input bit rv_, input bit rr_);
    bit ena, enb;
    logic [13:0] pa, pb;
    rst = r_; lv = lv_; rv = rv_; rr = rr_;
    @(negedge clk);
    ena = !mv_a[LA-1] | rr;
    enb = !mv_b[LB-1] | rr;
    check("a_lhs_ready", 32'(lrdy_a), ena & rv ? 32'h3fff : 32'h0);
    check("a_rhs_ready", 32'(rrdy_a), ena & lv ? 32'h3fff : 32'h0);
    check("a_valid",     32'(vld_a),  mv_a[LA-1] ? 32'h3fff : 32'h0);
    if (mv_a[LA-1]) check("a_result", 32'(res_a), 32'(mb_a[LA-1]));
    check("b_lhs_ready", 32'(lrdy_b), enb & rv ? 32'h3fff : 32'h0);
    check("b_rhs_ready", 32'(rrdy_b), enb & lv ? 32'h3fff : 32'h0);
    check("b_valid",     32'(vld_b),  mv_b[LB-1] ? 32'h3fff : 32'h0);
    if (mv_b[LB-1]) check("b_result", 32'(res_b), 32'(mb_b[LB-1]));
    pa = pred_vec(la, ra, 8, 23);
    pb = pred_vec(32'(lb), 32'(rb), 5, 10);
    fire_a = lv & rv & ena & !r_;
    @(posedge clk);
    if (r_) begin
      for (int i = 0; i < 4; i++) begin mv_a[i] = 0; mv_b[i] = 0; end
    end else begin
      if (ena) begin
        for (int i = 3; i > 0; i--) begin mv_a[i] = mv_a[i-1]; mb_a[i] = mb_a[i-1]; end
        mv_a[0] = lv & rv; mb_a[0] = pa;
      end
      if (enb) begin
        for (int i = 3; i > 0; i--) begin mv_b[i] = mv_b[i-1]; mb_b[i] = mb_b[i-1]; end
        mv_b[0] = lv & rv; mb_b[0] = pb;
      end
    end
    #1;
  endtask

  task automatic pair(input logic [31:0] a, input logic [31:0] b, input logic [15:0] ha, input logic [15:0] hb);
    la = a; ra = b; lb = ha; rb = hb;
    step(0, 1, 1, 1);
  endtask

  logic [31:0] s_l [6];
  logic [31:0] s_r [6];

  initial begin
    rst = 1; lv = 0; rv = 0; rr = 1;
    la = 0; ra = 0; lb = 0; rb = 0;
    for (int i = 0; i < 4; i++) begin mv_a[i] = 0; mv_b[i] = 0; mb_a[i] = 0; mb_b[i] = 0; end
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid_a", 32'(vld_a), 0);
    check("rst_result_a", 32'(res_a), 0);
    check("rst_valid_b", 32'(vld_b), 0);
    check("rst_ready_a", 32'(lrdy_a | rrdy_a), 0);
    step(0, 0, 0, 1);

    // Directed vectors; bank B results (LATENCY=1) are also checked against literal expectations.
    pair(32'h3F800000, 32'h40000000, 16'h3C00, 16'h4000);
    check("h_olt_1_2", 32'(res_b[3]), 1);
    pair(32'h40000000, 32'h3F800000, 16'h4000, 16'h3C00);
    check("h_olt_2_1", 32'(res_b[3]), 0);
    pair(32'h7FC00000, 32'h3F800000, 16'h7E00, 16'h3C00);
    check("h_nan_oeq", 32'(res_b[0]), 0);
    check("h_nan_ueq", 32'(res_b[7]), 1);
    check("h_nan_uno", 32'(res_b[13]), 1);
    pair(32'h80000000, 32'h00000000, 16'h8000, 16'h0000);
    check("h_zero_oeq", 32'(res_b[0]), 1);
    pair(32'hC0000000, 32'hBF800000, 16'h3C00, 16'hBC00);
    check("h_ogt_mixed", 32'(res_b[1]), 1);
    pair(32'h00000001, 32'h00000000, 16'h0001, 16'h0000);
`ifdef CMPF_PIPELINED_DAZ_EN
    check("h_daz_oeq", 32'(res_b[0]), 1);
`else
    check("h_daz_oeq", 32'(res_b[0]), 0);
`endif
    repeat (4) step(0, 0, 0, 1);

    // Stream of 6 pairs with downstream stalled in cycles 4..6.
    for (int i = 0; i < 6; i++) begin
      s_l[i] = rnd_fp(8, 23, 32'h3F800000);
      s_r[i] = rnd_fp(8, 23, s_l[i]);
    end
    begin
      int acc = 0;
      for (int c = 1; c <= 14; c++) begin
        if (acc < 6) begin la = s_l[acc]; ra = s_r[acc]; end
        lb = 16'($urandom); rb = 16'($urandom);
        step(0, acc < 6, acc < 6, !(c >= 4 && c <= 6));
        if (fire_a) acc++;
      end
      check("stream_accepted", 32'(acc), 6);
    end

    // Join: lhs alone must never be consumed.
    la = 32'h3F800000; ra = 32'h40000000; lb = 16'h3C00; rb = 16'h4000;
    repeat (5) step(0, 1, 0, 1);
    step(0, 1, 1, 1);
    repeat (4) step(0, 0, 0, 1);

    // Reset with two pairs in flight in bank A.
    step(0, 1, 1, 1);
    step(0, 1, 1, 1);
    step(1, 0, 0, 1);
    check("rst_mid_valid_a", 32'(vld_a), 0);
    check("rst_mid_valid_b", 32'(vld_b), 0);
    repeat (5) step(0, 0, 0, 1);

    for (int c = 0; c < 3000; c++) begin
      la = rnd_fp(8, 23, la);
      ra = rnd_fp(8, 23, la);
      lb = 16'(rnd_fp(5, 10, 32'(lb)));
      rb = 16'(rnd_fp(5, 10, 32'(lb)));
      step(($urandom % 250) == 0, ($urandom % 4) != 0, ($urandom % 4) != 0, ($urandom % 3) != 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
